// File: rtl/tone_sample_gen.sv
// Enveloped square-wave tone source feeding the Audio_Controller output FIFO.
// Optional build macro TONE_GEN_OVERRUN_CNT_EN adds the saturating overrun_count output.
module tone_sample_gen #(
  parameter int unsigned SAMPLE_DIV   = 1042,
  parameter logic [15:0] ATTACK_STEP  = 16'd1024,
  parameter logic [15:0] RELEASE_STEP = 16'd512,
  parameter int unsigned AMP_SHIFT    = 8
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [18:0] half_period,
  input  logic        audio_out_allowed,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        write_audio_out,
`ifdef TONE_GEN_OVERRUN_CNT_EN
  output logic [15:0] overrun_count,
`endif
  output logic [1:0]  state_dbg,
  output logic [15:0] env_dbg,
  output logic        snd_dbg
);

  localparam int unsigned       TICK_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state, eff_state, state_next;
  logic [15:0]       env, env_next;
  logic [16:0]       env_sum;
  logic [18:0]       cnt, period_q;
  logic              snd;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick, note_on, pending;
  logic [31:0]       sample_q, sample_val, mag;

  assign note_on = (half_period != 19'd0);
  assign tick    = (tick_cnt == TICK_LAST);
  assign env_sum = {1'b0, env} + {1'b0, ATTACK_STEP};

  // eff_state applies note on/off within the same cycle, so the envelope step on
  // that cycle already follows the new direction.
  always_comb begin
    eff_state = state;
    case (state)
      IDLE:            if (note_on)  eff_state = ATTACK;
      ATTACK, SUSTAIN: if (!note_on) eff_state = RELEASE;
      RELEASE:         if (note_on)  eff_state = ATTACK;
      default:         eff_state = IDLE;
    endcase

    env_next = env;
    if (tick) begin
      case (eff_state)
        ATTACK:  env_next = env_sum[16] ? 16'hFFFF : env_sum[15:0];
        RELEASE: env_next = (env < RELEASE_STEP) ? 16'd0 : env - RELEASE_STEP;
        default: env_next = env;
      endcase
    end

    state_next = eff_state;
    if (eff_state == ATTACK && env == 16'hFFFF) state_next = SUSTAIN;
    if (eff_state == RELEASE && env == 16'd0)   state_next = IDLE;

    mag        = 32'(env_next) << AMP_SHIFT;
    sample_val = (eff_state == IDLE) ? 32'd0 : (snd ? mag : 32'd0 - mag);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      env   <= 16'd0;
    end else begin
      state <= state_next;
      env   <= env_next;
    end
  end

  // Pitch is only picked up at a half-wave boundary, keeping the waveform phase-continuous.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt      <= 19'd0;
      snd      <= 1'b0;
      period_q <= 19'd0;
    end else if (state == IDLE) begin
      cnt <= 19'd0;
      snd <= 1'b0;
      if (note_on) period_q <= half_period;
    end else if (cnt == period_q) begin
      cnt <= 19'd0;
      snd <= ~snd;
      if (note_on) period_q <= half_period;
    end else begin
      cnt <= cnt + 19'd1;
    end
  end

  // pending is the valid and audio_out_allowed the ready of the FIFO handshake; a
  // sample transfers in any cycle where both are high, and write_audio_out marks it.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick_cnt <= '0;
      pending  <= 1'b0;
      sample_q <= 32'd0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      if (tick) begin
        sample_q <= sample_val;
        pending  <= 1'b1;
      end else if (write_audio_out) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef TONE_GEN_OVERRUN_CNT_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      overrun_count <= 16'd0;
    end else if (tick && pending && !audio_out_allowed && overrun_count != 16'hFFFF) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end
`endif

  assign write_audio_out         = pending & audio_out_allowed & ~reset;
  assign left_channel_audio_out  = reset ? 32'd0 : sample_q;
  assign right_channel_audio_out = reset ? 32'd0 : sample_q;
  assign state_dbg               = state;
  assign env_dbg                 = env;
  assign snd_dbg                 = snd;

endmodule

// File: tb/tb_tone_sample_gen.sv
// Self-checking bench for tone_sample_gen: directed envelope/handshake scenarios plus
// randomized note and back-pressure traffic against a cycle reference model.
module tb_tone_sample_gen;

  localparam int DIV    = 8;
  localparam int STEP_A = 16'h4000;
  localparam int STEP_R = 16'h4000;
  localparam int SHIFT  = 8;
  localparam int S_IDLE = 0, S_ATTACK = 1, S_SUSTAIN = 2, S_RELEASE = 3;
  localparam logic [31:0] FULL_POS = 32'h00FF_FF00;
  localparam logic [31:0] FULL_NEG = 32'hFF00_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [18:0] half_period = 19'd0;
  logic        allowed = 1'b1;
  logic [31:0] left, right;
  logic        write;
  logic [1:0]  state_dbg;
  logic [15:0] env_dbg;
  logic        snd_dbg;
`ifdef TONE_GEN_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  // Reference state, advanced once per rising edge by cycle().
  int m_state = 0, m_env = 0, m_cnt = 0, m_period = 0, m_snd = 0;
  int m_tick = 0, m_pending = 0, m_overrun = 0;
  logic [31:0] m_sample = 32'd0;

  tone_sample_gen #(
    .SAMPLE_DIV(DIV), .ATTACK_STEP(16'h4000), .RELEASE_STEP(16'h4000), .AMP_SHIFT(SHIFT)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .half_period(half_period),
    .audio_out_allowed(allowed),
    .left_channel_audio_out(left),
    .right_channel_audio_out(right),
    .write_audio_out(write),
`ifdef TONE_GEN_OVERRUN_CNT_EN
    .overrun_count(overrun_count),
`endif
    .state_dbg(state_dbg),
    .env_dbg(env_dbg),
    .snd_dbg(snd_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step();
    int eff, nenv;
    logic [31:0] mag;
    if (reset) begin
      m_state = S_IDLE; m_env = 0; m_cnt = 0; m_period = 0; m_snd = 0;
      m_tick = 0; m_pending = 0; m_overrun = 0; m_sample = 32'd0;
      return;
    end
    eff = m_state;
    if (half_period != 0 && (m_state == S_IDLE || m_state == S_RELEASE)) eff = S_ATTACK;
    if (half_period == 0 && (m_state == S_ATTACK || m_state == S_SUSTAIN)) eff = S_RELEASE;
    nenv = m_env;
    if (m_tick == DIV - 1) begin
      if (eff == S_ATTACK)  nenv = (m_env + STEP_A > 65535) ? 65535 : m_env + STEP_A;
      if (eff == S_RELEASE) nenv = (m_env < STEP_R) ? 0 : m_env - STEP_R;
      mag = 32'(nenv) << SHIFT;
      m_sample = (eff == S_IDLE) ? 32'd0 : ((m_snd != 0) ? mag : -mag);
      if (m_pending != 0 && !allowed && m_overrun < 65535) m_overrun++;
      m_pending = 1;
      m_tick = 0;
    end else begin
      if (m_pending != 0 && allowed) m_pending = 0;
      m_tick++;
    end
    if (m_state == S_IDLE) begin
      m_cnt = 0; m_snd = 0;
      if (half_period != 0) m_period = int'(half_period);
    end else if (m_cnt == m_period) begin
      m_cnt = 0; m_snd = 1 - m_snd;
      if (half_period != 0) m_period = int'(half_period);
    end else begin
      m_cnt++;
    end
    if (eff == S_ATTACK && m_env == 65535) m_state = S_SUSTAIN;
    else if (eff == S_RELEASE && m_env == 0) m_state = S_IDLE;
    else m_state = eff;
    m_env = nenv;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic exp_write();
    return (m_pending != 0) && (allowed === 1'b1) && (reset === 1'b0);
  endfunction

  function automatic logic [31:0] exp_out();
    return reset ? 32'd0 : m_sample;
  endfunction

  task automatic test_reset();
    int last, nw;
    reset = 1'b1; allowed = 1'b1; half_period = 19'd0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (write !== 1'b0 || left !== 32'd0 || right !== 32'd0 || state_dbg !== 2'(S_IDLE)) begin
        tests_failed++;
        $display("FAIL reset_hold write=%b left=%h right=%h state=%0d want 0,0,0,0",
                 write, left, right, state_dbg);
      end
      tests_run++;
    end
    reset = 1'b0;
    last = -1; nw = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (write === 1'b1) begin
        if (left !== 32'd0 || right !== 32'd0 || (last >= 0 && i - last != 8)) begin
          tests_failed++;
          $display("FAIL idle_write sample=%h,%h gap=%0d want 0,0 gap 8", left, right, i - last);
        end
        tests_run++;
        last = i; nw++;
      end
    end
    if (nw != 5 || state_dbg !== 2'(S_IDLE)) begin
      tests_failed++;
      $display("FAIL idle_write_count got %0d writes state %0d want 5 writes state 0", nw, state_dbg);
    end
    tests_run++;
  endtask

  task automatic test_attack();
    logic [15:0] seq[$];
    logic [15:0] prev_env;
    logic prev_snd, seen_full;
    int last_t, ntog, bad_gap;
    half_period = 19'd3; allowed = 1'b1;
    prev_env = env_dbg; prev_snd = snd_dbg; seen_full = 1'b0;
    last_t = -1; ntog = 0; bad_gap = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      if (write !== exp_write() || left !== exp_out() || right !== exp_out() ||
          state_dbg !== 2'(m_state) || env_dbg !== 16'(m_env)) begin
        tests_failed++;
        $display("FAIL attack_cycle t=%0t write=%b/%b out=%h,%h/%h state=%0d/%0d env=%h/%h",
                 $time, write, exp_write(), left, right, exp_out(), state_dbg, m_state,
                 env_dbg, m_env);
      end
      tests_run++;
      if (env_dbg !== prev_env) seq.push_back(env_dbg);
      prev_env = env_dbg;
      if (snd_dbg !== prev_snd) begin
        if (last_t >= 0 && i - last_t != 4) bad_gap++;
        last_t = i; ntog++;
      end
      prev_snd = snd_dbg;
      if (write === 1'b1 && (left === FULL_POS || left === FULL_NEG)) seen_full = 1'b1;
    end
    if (seq.size() != 4 || seq[0] !== 16'h4000 || seq[1] !== 16'h8000 ||
        seq[2] !== 16'hC000 || seq[3] !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL attack_env_seq got %p want 4000 8000 c000 ffff", seq);
    end
    tests_run++;
    if (state_dbg !== 2'(S_SUSTAIN)) begin
      tests_failed++;
      $display("FAIL attack_sustain state=%0d want %0d", state_dbg, S_SUSTAIN);
    end
    tests_run++;
    if (bad_gap != 0 || ntog < 5) begin
      tests_failed++;
      $display("FAIL attack_snd_period bad_gaps=%0d toggles=%0d want 0 bad, >=5 toggles", bad_gap, ntog);
    end
    tests_run++;
    if (!seen_full) begin
      tests_failed++;
      $display("FAIL attack_full_scale no write of magnitude 16776960 seen, last left=%h", left);
    end
    tests_run++;
  endtask

  task automatic test_release();
    logic [15:0] seq[$];
    logic [15:0] prev_env;
    logic [31:0] last_sample;
    half_period = 19'd0; allowed = 1'b1;
    prev_env = env_dbg; last_sample = 32'hDEAD_BEEF;
    for (int i = 0; i < 56; i++) begin
      cycle();
      if (write !== exp_write() || left !== exp_out() || right !== exp_out() ||
          state_dbg !== 2'(m_state) || env_dbg !== 16'(m_env)) begin
        tests_failed++;
        $display("FAIL release_cycle t=%0t write=%b/%b out=%h,%h/%h state=%0d/%0d env=%h/%h",
                 $time, write, exp_write(), left, right, exp_out(), state_dbg, m_state,
                 env_dbg, m_env);
      end
      tests_run++;
      if (env_dbg !== prev_env) seq.push_back(env_dbg);
      prev_env = env_dbg;
      if (write === 1'b1) last_sample = left;
    end
    if (seq.size() != 4 || seq[0] !== 16'hBFFF || seq[1] !== 16'h7FFF ||
        seq[2] !== 16'h3FFF || seq[3] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL release_env_seq got %p want bfff 7fff 3fff 0", seq);
    end
    tests_run++;
    if (state_dbg !== 2'(S_IDLE) || last_sample !== 32'd0) begin
      tests_failed++;
      $display("FAIL release_idle state=%0d last_sample=%h want 0, 0", state_dbg, last_sample);
    end
    tests_run++;
  endtask

  task automatic test_resume();
    logic ok, prev_snd;
    logic [15:0] prev_env, first_env;
    int tog[$];
    half_period = 19'd3; allowed = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      cycle();
      if (state_dbg === 2'(S_SUSTAIN)) ok = 1'b1;
    end
    half_period = 19'd0;
    for (int i = 0; i < 200 && ok && env_dbg !== 16'h7FFF; i++) cycle();
    if (!ok || env_dbg !== 16'h7FFF || state_dbg !== 2'(S_RELEASE)) begin
      tests_failed++;
      $display("FAIL resume_setup state=%0d env=%h want release at 7fff", state_dbg, env_dbg);
    end
    tests_run++;
    half_period = 19'd5;
    prev_env = env_dbg; prev_snd = snd_dbg; first_env = 16'h0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (write !== exp_write() || left !== exp_out() || right !== exp_out() ||
          state_dbg !== 2'(m_state) || env_dbg !== 16'(m_env)) begin
        tests_failed++;
        $display("FAIL resume_cycle t=%0t write=%b/%b out=%h/%h state=%0d/%0d env=%h/%h",
                 $time, write, exp_write(), left, exp_out(), state_dbg, m_state, env_dbg, m_env);
      end
      tests_run++;
      if (i == 0 && state_dbg !== 2'(S_ATTACK)) begin
        tests_failed++;
        $display("FAIL resume_state state=%0d want %0d", state_dbg, S_ATTACK);
      end
      if (i == 0) tests_run++;
      if (env_dbg !== prev_env && first_env == 16'h0) first_env = env_dbg;
      prev_env = env_dbg;
      if (snd_dbg !== prev_snd) tog.push_back(i);
      prev_snd = snd_dbg;
    end
    if (first_env !== 16'hBFFF) begin
      tests_failed++;
      $display("FAIL resume_env first env after resume=%h want bfff", first_env);
    end
    tests_run++;
    if (tog.size() < 3 || tog[0] > 3 || tog[1] - tog[0] != 6 || tog[2] - tog[1] != 6) begin
      tests_failed++;
      $display("FAIL resume_phase toggles at %p want first <=3 then gaps of 6", tog);
    end
    tests_run++;
    half_period = 19'd0;
    for (int i = 0; i < 200 && state_dbg !== 2'(S_IDLE); i++) cycle();
  endtask

  task automatic test_overrun();
    logic ok;
    int nw;
`ifdef TONE_GEN_OVERRUN_CNT_EN
    logic [15:0] ovr0;
`endif
    half_period = 19'd3; allowed = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      cycle();
      if (state_dbg === 2'(S_SUSTAIN)) ok = 1'b1;
    end
    for (int i = 0; i < 20 && ok && write !== 1'b1; i++) cycle();
    if (!ok || write !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_setup state=%0d write=%b want sustain with write", state_dbg, write);
    end
    tests_run++;
    allowed = 1'b0;
`ifdef TONE_GEN_OVERRUN_CNT_EN
    ovr0 = overrun_count;
`endif
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (write !== 1'b0) nw++;
    end
    if (nw != 0) begin
      tests_failed++;
      $display("FAIL overrun_blocked got %0d writes while not allowed want 0", nw);
    end
    tests_run++;
`ifdef TONE_GEN_OVERRUN_CNT_EN
    if (overrun_count - ovr0 !== 16'd2 || overrun_count !== 16'(m_overrun)) begin
      tests_failed++;
      $display("FAIL overrun_count got %0d (start %0d) want +2, model %0d", overrun_count, ovr0, m_overrun);
    end
    tests_run++;
`endif
    allowed = 1'b1;
    #1;
    if (write !== 1'b1 || left !== m_sample || (left !== FULL_POS && left !== FULL_NEG)) begin
      tests_failed++;
      $display("FAIL overrun_release write=%b left=%h want 1, %h", write, left, m_sample);
    end
    tests_run++;
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (write === 1'b1) nw++;
    end
    if (nw != 0) begin
      tests_failed++;
      $display("FAIL overrun_single got %0d extra writes want 0", nw);
    end
    tests_run++;
  endtask

  task automatic test_reset_mid();
    int nw;
    half_period = 19'd0; allowed = 1'b1;
    for (int i = 0; i < 200 && state_dbg !== 2'(S_IDLE); i++) cycle();
    allowed = 1'b0; half_period = 19'd3;
    for (int i = 0; i < 40 && env_dbg === 16'h0; i++) cycle();
    if (state_dbg !== 2'(S_ATTACK) || env_dbg === 16'h0 || m_pending == 0) begin
      tests_failed++;
      $display("FAIL resetmid_setup state=%0d env=%h want attack, env>0, pending", state_dbg, env_dbg);
    end
    tests_run++;
    reset = 1'b1; allowed = 1'b1;
    cycle();
    if (write !== 1'b0 || left !== 32'd0 || right !== 32'd0 || env_dbg !== 16'd0 ||
        state_dbg !== 2'(S_IDLE)) begin
      tests_failed++;
      $display("FAIL resetmid_state write=%b out=%h,%h env=%h state=%0d want all 0",
               write, left, right, env_dbg, state_dbg);
    end
    tests_run++;
    reset = 1'b0; half_period = 19'd0;
    nw = 0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (write === 1'b1) nw++;
    end
    if (nw != 0) begin
      tests_failed++;
      $display("FAIL resetmid_dropped got %0d writes after reset want 0", nw);
    end
    tests_run++;
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0)
        half_period = ($urandom_range(0, 2) == 0) ? 19'd0 : 19'($urandom_range(1, 6));
      allowed = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      cycle();
      if (write !== exp_write() || left !== exp_out() || right !== exp_out() ||
          state_dbg !== 2'(m_state) || env_dbg !== 16'(m_env)) begin
        tests_failed++;
        $display("FAIL random_cycle t=%0t write=%b/%b out=%h,%h/%h state=%0d/%0d env=%h/%h",
                 $time, write, exp_write(), left, right, exp_out(), state_dbg, m_state,
                 env_dbg, m_env);
      end
      tests_run++;
`ifdef TONE_GEN_OVERRUN_CNT_EN
      if (overrun_count !== 16'(m_overrun)) begin
        tests_failed++;
        $display("FAIL random_overrun got %0d want %0d", overrun_count, m_overrun);
      end
      tests_run++;
`endif
      if (exp_write()) exp_q.push_back(m_sample);
      if (write === 1'b1) begin
        got = left;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL random_scoreboard unexpected write of %h", got);
        end else if (exp_q[0] !== got) begin
          tests_failed++;
          $display("FAIL random_scoreboard wrote %h want %h", got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        tests_run++;
      end
    end
    reset = 1'b0;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL random_drain %0d expected writes never seen want 0", exp_q.size());
    end
    tests_run++;
  endtask

  initial begin
    test_reset();
    test_attack();
    test_release();
    test_resume();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
